// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-RAM arbiter slice.
//   arb_state_t : arbiter FSM state (free / locked to m0 / locked to m1)
//   resp_tag_t  : one-deep response pipeline tag (owner, read flag, range error)
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_DEPTH  = 328;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic master;   // 0 = m0, 1 = m1
    logic is_read;  // a read was granted last cycle
    logic err;      // the granted address was out of range
  } resp_tag_t;

  localparam resp_tag_t RESP_TAG_NONE = '{master: 1'b0, is_read: 1'b0, err: 1'b0};

endpackage

// File: rtl/dmem_arbiter_if.sv
// Per-requester data-RAM access port.
//   master modport : drives req/we/lock/addr/wdata, receives gnt/rvalid/rdata/err
//   slave modport  : the arbiter side of the same signals
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
) ();

  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way round-robin selector.
//   req   : requests {m1, m0}
//   ptr   : master favoured on a tie while free (0 = m0)
//   state : arbiter state; a locked state admits only its owner
//   grant : one-hot (or zero) grant {m1, m0}
module rr_pick
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  arb_state_t state,
  output logic [1:0] grant
);

  // Pure combinational pick; no state lives here.
  always_comb begin
    grant = 2'b00;
    case (state)
      IDLE: begin
        if (req == 2'b11) begin
          grant = ptr ? 2'b10 : 2'b01;
        end else begin
          grant = req;
        end
      end
      LOCK0:   grant = {1'b0, req[0]};
      LOCK1:   grant = {req[1], 1'b0};
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter and sequencer sharing the single-port data RAM between the CPU
// load/store unit (m0) and the phrase/display reader (m1).
//   clock, reset : single clock, synchronous active-high reset
//   m0, m1       : requester ports (dmem_arbiter_if slave modport)
//   ram_address, ram_data, ram_wren : RAM drive; address/data hold when idle
//   ram_q        : RAM registered read data (valid the cycle after the address)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned DEPTH  = DMEM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  arb_state_t        state_q, state_d;
  logic              ptr_q, ptr_d;
  resp_tag_t         tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic [1:0]        grant_raw;
  logic [1:0]        grant;
  logic              any_gnt;
  logic              sel;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  rr_pick u_rr_pick (
    .req   ({m1.req, m0.req}),
    .ptr   (ptr_q),
    .state (state_q),
    .grant (grant_raw)
  );

  // No grant may leave the arbiter while reset is held.
  assign grant   = reset ? 2'b00 : grant_raw;
  assign any_gnt = |grant;
  assign sel     = grant[1];

  // Granted master's request fields.
  assign sel_we    = sel ? m1.we    : m0.we;
  assign sel_lock  = sel ? m1.lock  : m0.lock;
  assign sel_addr  = sel ? m1.addr  : m0.addr;
  assign sel_wdata = sel ? m1.wdata : m0.wdata;
  assign in_range  = (sel_addr < ADDR_W'(DEPTH));

  // Next state, pointer, response tag and RAM drive.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tag_d       = RESP_TAG_NONE;
    ram_address = addr_q;
    ram_data    = data_q;
    ram_wren    = 1'b0;

    if (any_gnt) begin
      ram_address   = sel_addr;
      ram_data      = sel_wdata;
      ram_wren      = sel_we & in_range;
      tag_d.master  = sel;
      tag_d.is_read = ~sel_we;
      tag_d.err     = ~in_range;
    end

    case (state_q)
      IDLE: begin
        if (any_gnt) begin
          ptr_d = ~sel;
          if (sel_lock) begin
            state_d = sel ? LOCK1 : LOCK0;
          end
        end
      end
      // Owner either dropped req (abandoned) or made its final unlocked access.
      LOCK0: begin
        if (!m0.req || !m0.lock) begin
          state_d = IDLE;
        end
      end
      LOCK1: begin
        if (!m1.req || !m1.lock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, response tag and held RAM address/data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      tag_q   <= RESP_TAG_NONE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      addr_q  <= ram_address;
      data_q  <= ram_data;
    end
  end

  // Response decode from the registered tag; ram_q lines up with it.
  // Reset masks the slot so a read granted just before reset never completes.
  assign m0.gnt    = grant[0];
  assign m1.gnt    = grant[1];
  assign m0.rvalid = ~reset & tag_q.is_read & ~tag_q.master;
  assign m1.rvalid = ~reset & tag_q.is_read &  tag_q.master;
  assign m0.err    = ~reset & tag_q.err & ~tag_q.master;
  assign m1.err    = ~reset & tag_q.err &  tag_q.master;
  assign m0.rdata  = (m0.rvalid && !tag_q.err) ? ram_q : '0;
  assign m1.rdata  = (m1.rvalid && !tag_q.err) ? ram_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural registered-read RAM.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = DMEM_DEPTH;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q = 32'h0;
  logic [31:0] mem [0:DEPTH-1];
  logic        mem_loaded = 1'b0;

  int checks   = 0;
  int failures = 0;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  always #5 clock = ~clock;

  // Single-port RAM, registered read returning old data on read-during-write.
  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem_loaded <= 1'b1;
    end else if (ram_wren && ram_address < DEPTH) begin
      mem[ram_address[8:0]] <= ram_data;
    end
    ram_q <= (ram_address < DEPTH) ? mem[ram_address[8:0]] : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv0(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wdata);
    m0_if.req = req; m0_if.we = we; m0_if.lock = lock;
    m0_if.addr = addr; m0_if.wdata = wdata;
  endtask

  task automatic drv1(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wdata);
    m1_if.req = req; m1_if.we = we; m1_if.lock = lock;
    m1_if.addr = addr; m1_if.wdata = wdata;
  endtask

  initial begin
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    tick();
    tick();

    // Reset state, with a request present that must not be granted.
    drv0(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    #1;
    chk("rst_gnt0", 32'(m0_if.gnt), 32'd0);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_addr", ram_address, 32'd0);
    chk("rst_data", ram_data, 32'd0);
    chk("rst_rvalid0", 32'(m0_if.rvalid), 32'd0);
    chk("rst_err0", 32'(m0_if.err), 32'd0);
    chk("rst_rdata0", m0_if.rdata, 32'd0);

    // m0 write then read addr 5.
    tick(); reset = 1'b0;
    drv0(1'b1, 1'b1, 1'b0, 32'd5, 32'hDEADBEEF);
    #1;
    chk("t1_wr_gnt0", 32'(m0_if.gnt), 32'd1);
    chk("t1_wr_gnt1", 32'(m1_if.gnt), 32'd0);
    chk("t1_wr_wren", 32'(ram_wren), 32'd1);
    chk("t1_wr_addr", ram_address, 32'd5);
    chk("t1_wr_data", ram_data, 32'hDEADBEEF);
    tick();
    drv0(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    #1;
    chk("t1_rd_gnt0", 32'(m0_if.gnt), 32'd1);
    chk("t1_rd_wren", 32'(ram_wren), 32'd0);
    chk("t1_wr_no_rvalid", 32'(m0_if.rvalid), 32'd0);
    chk("t1_wr_no_err", 32'(m0_if.err), 32'd0);
    tick();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("t1_rvalid0", 32'(m0_if.rvalid), 32'd1);
    chk("t1_rdata0", m0_if.rdata, 32'hDEADBEEF);
    chk("t1_rvalid1", 32'(m1_if.rvalid), 32'd0);
    chk("t1_gnt1_idle", 32'(m1_if.gnt), 32'd0);
    chk("t1_addr_hold", ram_address, 32'd5);

    // Reset so the pointer favours m0 again.
    tick(); reset = 1'b1;
    #1;

    // Both read continuously: alternate m0, m1, m0, m1.
    tick(); reset = 1'b0;
    drv0(1'b1, 1'b0, 1'b0, 32'd10, 32'd0);
    drv1(1'b1, 1'b0, 1'b0, 32'd20, 32'd0);
    #1;
    chk("t2_c1_gnt0", 32'(m0_if.gnt), 32'd1);
    chk("t2_c1_gnt1", 32'(m1_if.gnt), 32'd0);
    tick(); #1;
    chk("t2_c2_gnt1", 32'(m1_if.gnt), 32'd1);
    chk("t2_c2_gnt0", 32'(m0_if.gnt), 32'd0);
    chk("t2_c2_rvalid0", 32'(m0_if.rvalid), 32'd1);
    chk("t2_c2_rdata0", m0_if.rdata, 32'h1000_000A);
    chk("t2_c2_rvalid1", 32'(m1_if.rvalid), 32'd0);
    tick(); #1;
    chk("t2_c3_gnt0", 32'(m0_if.gnt), 32'd1);
    chk("t2_c3_rvalid1", 32'(m1_if.rvalid), 32'd1);
    chk("t2_c3_rdata1", m1_if.rdata, 32'h1000_0014);
    chk("t2_c3_rvalid0", 32'(m0_if.rvalid), 32'd0);
    tick(); #1;
    chk("t2_c4_gnt1", 32'(m1_if.gnt), 32'd1);
    chk("t2_c4_rdata0", m0_if.rdata, 32'h1000_000A);
    tick();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("t2_c5_rvalid1", 32'(m1_if.rvalid), 32'd1);
    chk("t2_c5_rdata1", m1_if.rdata, 32'h1000_0014);

    // Lock by m1; a lone m0 access first hands the pointer to m1.
    tick(); reset = 1'b1;
    #1;
    tick(); reset = 1'b0;
    drv0(1'b1, 1'b1, 1'b0, 32'd9, 32'h99);
    #1;
    chk("t3_pre_gnt0", 32'(m0_if.gnt), 32'd1);
    tick();
    drv0(1'b1, 1'b0, 1'b0, 32'd7, 32'd0);
    drv1(1'b1, 1'b0, 1'b1, 32'd7, 32'd0);
    #1;
    chk("t3_c1_gnt1", 32'(m1_if.gnt), 32'd1);
    chk("t3_c1_gnt0", 32'(m0_if.gnt), 32'd0);
    tick();
    drv1(1'b1, 1'b1, 1'b0, 32'd7, 32'hCAFE0007);
    #1;
    chk("t3_c2_gnt1", 32'(m1_if.gnt), 32'd1);
    chk("t3_c2_gnt0", 32'(m0_if.gnt), 32'd0);
    chk("t3_c2_rvalid1", 32'(m1_if.rvalid), 32'd1);
    chk("t3_c2_rdata1", m1_if.rdata, 32'h1000_0007);
    chk("t3_c2_wren", 32'(ram_wren), 32'd1);
    chk("t3_c2_addr", ram_address, 32'd7);
    tick();
    drv1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("t3_c3_gnt0", 32'(m0_if.gnt), 32'd1);
    chk("t3_c3_gnt1", 32'(m1_if.gnt), 32'd0);
    tick();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("t3_c4_rvalid0", 32'(m0_if.rvalid), 32'd1);
    chk("t3_c4_rdata0", m0_if.rdata, 32'hCAFE0007);
    chk("t3_mem7", mem[7], 32'hCAFE0007);

    // m0 locks, then abandons by dropping req; m1 waits one cycle.
    tick();
    drv0(1'b1, 1'b0, 1'b1, 32'd3, 32'd0);
    #1;
    chk("t3b_lock_gnt0", 32'(m0_if.gnt), 32'd1);
    tick();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv1(1'b1, 1'b0, 1'b0, 32'd4, 32'd0);
    #1;
    chk("t3b_locked_out_gnt1", 32'(m1_if.gnt), 32'd0);
    tick(); #1;
    chk("t3b_abandon_gnt1", 32'(m1_if.gnt), 32'd1);
    tick();
    drv1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;

    // Out-of-range read then write.
    tick();
    drv0(1'b1, 1'b0, 1'b0, 32'd328, 32'd0);
    #1;
    chk("t4_rd_gnt0", 32'(m0_if.gnt), 32'd1);
    chk("t4_rd_wren", 32'(ram_wren), 32'd0);
    tick();
    drv0(1'b1, 1'b1, 1'b0, 32'd400, 32'h1);
    #1;
    chk("t4_wr_gnt0", 32'(m0_if.gnt), 32'd1);
    chk("t4_wr_wren", 32'(ram_wren), 32'd0);
    chk("t4_rd_err0", 32'(m0_if.err), 32'd1);
    chk("t4_rd_rvalid0", 32'(m0_if.rvalid), 32'd1);
    chk("t4_rd_rdata0", m0_if.rdata, 32'd0);
    tick();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("t4_wr_err0", 32'(m0_if.err), 32'd1);
    chk("t4_wr_rvalid0", 32'(m0_if.rvalid), 32'd0);
    chk("t4_idle_wren", 32'(ram_wren), 32'd0);
    tick(); #1;
    chk("t4_err_cleared", 32'(m0_if.err), 32'd0);

    // m1 locked read, then reset with m1 still requesting a lock.
    tick();
    drv1(1'b1, 1'b0, 1'b1, 32'd10, 32'd0);
    #1;
    chk("t5_gnt1", 32'(m1_if.gnt), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("t5_rst_rvalid1", 32'(m1_if.rvalid), 32'd0);
    chk("t5_rst_gnt1", 32'(m1_if.gnt), 32'd0);
    tick();
    reset = 1'b0;
    drv0(1'b1, 1'b0, 1'b0, 32'd20, 32'd0);
    drv1(1'b1, 1'b0, 1'b0, 32'd10, 32'd0);
    #1;
    chk("t5_post_rvalid1", 32'(m1_if.rvalid), 32'd0);
    chk("t5_post_gnt0", 32'(m0_if.gnt), 32'd1);
    chk("t5_post_gnt1", 32'(m1_if.gnt), 32'd0);
    tick(); #1;
    chk("t5_next_gnt1", 32'(m1_if.gnt), 32'd1);
    chk("t5_next_rdata0", m0_if.rdata, 32'h1000_0014);
    tick();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("t5_last_rvalid1", 32'(m1_if.rvalid), 32'd1);
    chk("t5_last_rdata1", m1_if.rdata, 32'h1000_000A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single-port data RAM: it shares the RAM between two requesters, the CPU load/store unit (m0) and the phrase-processing/display reader (m1). It supports round-robin arbitration, a lock for atomic read-modify-write sequences, range checking against the RAM depth, and read-response routing that matches the RAM's one-cycle registered read. It sits between both masters and the RAM's address/data/wren/q pins.

## Interface
- ADDR_W, 32, address width of masters and RAM
- DATA_W, 32, data word width
- DEPTH, 328, number of RAM words; valid addresses are 0..DEPTH-1
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- m0_req / m1_req  in  1  access request, held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_lock / m1_lock  in  1  keep ownership after this access
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  access accepted this cycle (combinational from req and registered state)
- m0_rvalid / m1_rvalid  out  1  read data valid (registered)
- m0_rdata / m1_rdata  out  DATA_W  read data (registered)
- m0_err / m1_err  out  1  one-cycle pulse, coincident with rvalid slot, for out-of-range access
- ram_address  out  ADDR_W  to RAM address
- ram_data  out  DATA_W  to RAM data
- ram_wren  out  1  to RAM write enable
- ram_q  in  DATA_W  RAM registered read data

## Operation
- FSM states: IDLE, LOCK0, LOCK1. Reset state: IDLE. The round-robin pointer resets to 0, giving m0 priority.
- In IDLE, a single requester is granted immediately.
- In IDLE with both requesting, the pointer's master is granted, and the pointer moves to the other master after every grant made in IDLE.
- LOCKx: only mx can be granted, and the other master waits with its req held. The lock state continues while mx is granted with mx_lock=1.
- A grant with mx_lock=1 from IDLE moves the FSM to LOCKx.
- In LOCKx, a grant with mx_lock=0 returns the FSM to IDLE.
- In LOCKx, mx_req=0 for one cycle returns the FSM to IDLE (lock abandoned).
- RAM drive:
  - In a granted cycle: ram_address = granted addr, ram_data = granted wdata, ram_wren = we & in-range.
  - When nothing is granted: ram_wren = 0, and address/data hold the last value.
- Out-of-range (addr >= DEPTH): still granted. No RAM write. A read returns rdata = 0. mx_err pulses in the cycle after the grant, for both reads and writes.
- Reads: mx_rvalid pulses in the cycle after the grant, with mx_rdata = ram_q. Writes produce no rvalid.
- Response routing uses a registered tag (granted master, read flag, err flag). Tags are only a pipeline stage and are never queued.

## Timing
- Reset values: all gnt 0 during reset; rvalid 0, rdata 0, err 0, ram_wren 0, ram_address 0, ram_data 0.
- Grant latency: the request cycle itself when the master is eligible. Read latency: 1 cycle, grant at cycle N → rvalid at N+1.
- Throughput: one access per cycle. Back-to-back grants are allowed, including a read followed by a write to the same address. The RAM returns old data for the read.
- Simultaneous requests in a cycle grant exactly one master. The loser's req must stay high, and it is granted next cycle unless the winner locked.
- Reset asserted mid-operation clears the pending response tag: no rvalid is issued for a read granted in the cycle before reset. The FSM goes to IDLE and the pointer to 0.
- Masters must not change addr/we/wdata/lock while req=1 and gnt=0.

## Structure
- Shared package dmem_pkg holds:
  - the arb_state_t enum (IDLE, LOCK0, LOCK1);
  - the DMEM_DEPTH = 328 constant;
  - the resp_tag_t struct {master, is_read, err}.
- One sub-module, rr_pick: a 2-way round-robin selector with inputs req[1:0], ptr, and state, and output grant[1:0]. The FSM, RAM mux and response stage live in dmem_arbiter.

## Test plan
- After reset, m0 writes 0xDEADBEEF to addr 5, then reads addr 5 → write gnt at cycle 1, read gnt at cycle 2, m0_rvalid at cycle 3 with 0xDEADBEEF, m1 outputs idle.
- Both request reads of addrs 10/20 continuously for 4 cycles → grants alternate m0, m1, m0, m1; each rvalid arrives one cycle later with the matching RAM contents.
- m1 locks: read addr 7 with lock=1, then write addr 7 with lock=0 while m0 requests throughout → m0_gnt stays 0 for both cycles and is granted on cycle 3; RAM addr 7 shows the new value.
- m0 reads addr 328, then writes addr 400 with data 0x1 → both granted; m0_err pulses the cycle after each; rdata = 0 for the read; RAM contents unchanged; ram_wren never high.
- Reset asserted the cycle after an m1 read grant → m1_rvalid stays 0, the FSM is in IDLE, and a subsequent simultaneous request grants m0 first.
